// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong controller for the two beatmap line RAMs: the producer fills one bank
// while the display side replays the other; banks swap only when full and the reader is idle.
//
// writer state | meaning
// W_FILL       | accepting producer words into bank bank_sel
// W_FULL       | bank complete, waiting for the reader to go idle before swapping
//
// reader state | meaning
// R_IDLE       | no replay in progress; waiting for rd_start or a pending request
// R_READ       | issuing read enables for addresses 0..DEPTH-1 of bank rbank_q
// R_DRAIN      | one cycle for the final registered RAM word to emerge
module pingpong_bank_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_start,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_underrun,
    output logic              bank_sel,
    output logic              swap,
    output logic              ram1_we,
    output logic              ram2_we,
    output logic [ADDR_W-1:0] ram1_waddr,
    output logic [ADDR_W-1:0] ram2_waddr,
    output logic [DATA_W-1:0] ram1_wdata,
    output logic [DATA_W-1:0] ram2_wdata,
    output logic              ram1_re,
    output logic              ram2_re,
    output logic [ADDR_W-1:0] ram1_raddr,
    output logic [ADDR_W-1:0] ram2_raddr,
    input  logic [DATA_W-1:0] ram1_rdata,
    input  logic [DATA_W-1:0] ram2_rdata
);

    localparam logic              W_FILL  = 1'b0;
    localparam logic              W_FULL  = 1'b1;
    localparam logic [1:0]        R_IDLE  = 2'd0;
    localparam logic [1:0]        R_READ  = 2'd1;
    localparam logic [1:0]        R_DRAIN = 2'd2;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic              wstate;
    logic [1:0]        rstate;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] raddr;
    logic              rbank_valid;
    logic              rbank_q;
    logic              rd_pend;
    logic              wr_fire;
    logic              swap_now;
    logic              rd_go;
    logic              rd_issue;

    assign wr_ready = (wstate == W_FILL) && !reset;
    assign wr_fire  = wr_valid && wr_ready;
    assign swap_now = (wstate == W_FULL) && (rstate == R_IDLE);
    assign rd_go    = (rstate == R_IDLE) && (rd_start || rd_pend) && rbank_valid && !swap_now;
    assign rd_issue = (rstate == R_READ) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate      <= W_FILL;
            rstate      <= R_IDLE;
            wcnt        <= '0;
            raddr       <= '0;
            bank_sel    <= 1'b0;
            rbank_valid <= 1'b0;
            rbank_q     <= 1'b0;
            rd_pend     <= 1'b0;
            swap        <= 1'b0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            rd_underrun <= 1'b0;
        end else begin
            swap        <= swap_now;
            rd_valid    <= rd_issue;
            rd_last     <= rd_issue && (raddr == LAST);
            rd_underrun <= (rstate == R_IDLE) && rd_start && !rbank_valid && !swap_now;

            if (swap_now) begin
                bank_sel    <= ~bank_sel;
                rbank_valid <= 1'b1;
                wcnt        <= '0;
                wstate      <= W_FILL;
            end else if (wr_fire) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST)
                    wstate <= W_FULL;
            end

            case (rstate)
                R_IDLE: begin
                    // a request landing on the swap cycle waits one cycle for the new bank
                    if (swap_now && rd_start)
                        rd_pend <= 1'b1;
                    if (rd_go) begin
                        rd_pend <= 1'b0;
                        rbank_q <= ~bank_sel;
                        raddr   <= '0;
                        rstate  <= R_READ;
                    end
                end
                R_READ: begin
                    if (raddr == LAST) begin
                        raddr  <= '0;
                        rstate <= R_DRAIN;
                    end else begin
                        raddr <= raddr + 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign ram1_we    = wr_fire && !bank_sel;
    assign ram2_we    = wr_fire && bank_sel;
    assign ram1_waddr = wcnt;
    assign ram2_waddr = wcnt;
    assign ram1_wdata = wr_data;
    assign ram2_wdata = wr_data;
    assign ram1_re    = rd_issue && !rbank_q;
    assign ram2_re    = rd_issue && rbank_q;
    assign ram1_raddr = raddr;
    assign ram2_raddr = raddr;
    assign rd_data    = rd_valid ? (rbank_q ? ram2_rdata : ram1_rdata) : '0;

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl with behavioural RAMs of registered read latency.
module tb_pingpong_bank_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_ready;
    logic       rd_start = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_underrun;
    logic       bank_sel;
    logic       swap;
    logic       ram1_we, ram2_we;
    logic [4:0] ram1_waddr, ram2_waddr;
    logic [7:0] ram1_wdata, ram2_wdata;
    logic       ram1_re, ram2_re;
    logic [4:0] ram1_raddr, ram2_raddr;
    logic [7:0] ram1_rdata = 8'd0;
    logic [7:0] ram2_rdata = 8'd0;

    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];

    int checks = 0;
    int errors = 0;

    pingpong_bank_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_start(rd_start), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .rd_underrun(rd_underrun),
        .bank_sel(bank_sel), .swap(swap),
        .ram1_we(ram1_we), .ram2_we(ram2_we),
        .ram1_waddr(ram1_waddr), .ram2_waddr(ram2_waddr),
        .ram1_wdata(ram1_wdata), .ram2_wdata(ram2_wdata),
        .ram1_re(ram1_re), .ram2_re(ram2_re),
        .ram1_raddr(ram1_raddr), .ram2_raddr(ram2_raddr),
        .ram1_rdata(ram1_rdata), .ram2_rdata(ram2_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram1_we) mem1[ram1_waddr] <= ram1_wdata;
        if (ram2_we) mem2[ram2_waddr] <= ram2_wdata;
        if (ram1_re) ram1_rdata <= mem1[ram1_raddr];
        if (ram2_re) ram2_rdata <= mem2[ram2_raddr];
    end

    // inputs change 1 time unit after the edge, outputs are sampled 2 units after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (wr_ready !== 1'b0 || bank_sel !== 1'b0 || swap !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl wr_ready=%b bank_sel=%b swap=%b required 0 0 0", wr_ready, bank_sel, swap);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_underrun !== 1'b0 || rd_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_rd valid=%b last=%b underrun=%b data=%0d required all 0", rd_valid, rd_last, rd_underrun, rd_data);
        end
        checks++;
        if ({ram1_we, ram2_we, ram1_re, ram2_re} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ram we/re=%b required 0000", {ram1_we, ram2_we, ram1_re, ram2_re});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_underrun();
        int pulses = 0;
        for (int k = 0; k < 4; k++) begin
            rd_start = (k == 0);
            #1;
            if (rd_underrun === 1'b1) pulses++;
            checks++;
            if (rd_valid !== 1'b0 || ram1_re !== 1'b0 || ram2_re !== 1'b0) begin
                errors++;
                $display("FAIL underrun_noread k=%0d rd_valid=%b re=%b%b required 0", k, rd_valid, ram1_re, ram2_re);
            end
            tick();
        end
        rd_start = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL underrun_pulse got %0d pulses required 1", pulses);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            #1;
            checks++;
            if (wr_ready !== 1'b1 || ram1_we !== 1'b1 || ram2_we !== 1'b0 ||
                ram1_waddr !== 5'(i) || ram1_wdata !== 8'(i)) begin
                errors++;
                $display("FAIL fill_word i=%0d ready=%b we1=%b we2=%b waddr=%0d wdata=%0d required 1 1 0 %0d %0d",
                         i, wr_ready, ram1_we, ram2_we, ram1_waddr, ram1_wdata, i, i);
            end
            tick();
        end
        wr_data = 8'd99;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || ram1_we !== 1'b0 || ram2_we !== 1'b0 || swap !== 1'b0 || bank_sel !== 1'b0) begin
            errors++;
            $display("FAIL fill_gap ready=%b we=%b%b swap=%b bank_sel=%b required 0 00 0 0",
                     wr_ready, ram1_we, ram2_we, swap, bank_sel);
        end
        tick();
        wr_data = 8'd100;
        #1;
        checks++;
        if (swap !== 1'b1 || bank_sel !== 1'b1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_swap swap=%b bank_sel=%b ready=%b required 1 1 1", swap, bank_sel, wr_ready);
        end
        checks++;
        if (ram2_we !== 1'b1 || ram1_we !== 1'b0 || ram2_waddr !== 5'd0) begin
            errors++;
            $display("FAIL fill_next_bank we2=%b we1=%b waddr=%0d required 1 0 0", ram2_we, ram1_we, ram2_waddr);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    // replay ram1 (0..31) while words 1..31 of the second fill go to ram2
    task automatic test_replay_with_fill();
        logic [7:0] exp_d;
        for (int k = 0; k <= 36; k++) begin
            rd_start = (k == 0);
            wr_valid = (k < 35);
            wr_data  = 8'(101 + k);
            #1;
            exp_d = (k >= 2 && k <= 33) ? 8'(k - 2) : 8'd0;
            checks++;
            if (rd_valid !== (k >= 2 && k <= 33) || rd_data !== exp_d || rd_last !== (k == 33)) begin
                errors++;
                $display("FAIL replay1_out k=%0d valid=%b data=%0d last=%b required %b %0d %b",
                         k, rd_valid, rd_data, rd_last, (k >= 2 && k <= 33), exp_d, (k == 33));
            end
            checks++;
            if (ram1_re !== (k >= 1 && k <= 32) || ram2_re !== 1'b0 ||
                (ram1_re === 1'b1 && ram1_raddr !== 5'(k - 1))) begin
                errors++;
                $display("FAIL replay1_re k=%0d re1=%b re2=%b raddr=%0d", k, ram1_re, ram2_re, ram1_raddr);
            end
            checks++;
            if (wr_ready !== (k <= 30 || k >= 35) || ram2_we !== (k <= 30) || ram1_we !== 1'b0 ||
                (k <= 30 && ram2_waddr !== 5'(k + 1))) begin
                errors++;
                $display("FAIL replay1_wr k=%0d ready=%b we2=%b we1=%b waddr=%0d required %b %b 0",
                         k, wr_ready, ram2_we, ram1_we, ram2_waddr, (k <= 30 || k >= 35), (k <= 30));
            end
            checks++;
            if (swap !== (k == 35) || bank_sel !== (k < 35)) begin
                errors++;
                $display("FAIL replay1_swap k=%0d swap=%b bank_sel=%b required %b %b",
                         k, swap, bank_sel, (k == 35), (k < 35));
            end
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_replay_new_bank();
        logic [7:0] exp_d;
        for (int k = 0; k <= 34; k++) begin
            rd_start = (k == 0);
            #1;
            exp_d = (k >= 2 && k <= 33) ? 8'(100 + k - 2) : 8'd0;
            checks++;
            if (rd_valid !== (k >= 2 && k <= 33) || rd_data !== exp_d || rd_last !== (k == 33)) begin
                errors++;
                $display("FAIL replay2_out k=%0d valid=%b data=%0d last=%b required %b %0d %b",
                         k, rd_valid, rd_data, rd_last, (k >= 2 && k <= 33), exp_d, (k == 33));
            end
            checks++;
            if (ram2_re !== (k >= 1 && k <= 32) || ram1_re !== 1'b0) begin
                errors++;
                $display("FAIL replay2_re k=%0d re2=%b re1=%b", k, ram2_re, ram1_re);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(200 + i);
            #1;
            checks++;
            if (wr_ready !== 1'b1 || ram1_we !== 1'b1 || ram1_waddr !== 5'(i)) begin
                errors++;
                $display("FAIL b2b_fill i=%0d ready=%b we1=%b waddr=%0d", i, wr_ready, ram1_we, ram1_waddr);
            end
            tick();
        end
        wr_valid = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            rd_start = (k == 0 || k == 10);
            #1;
            exp_d = (k >= 3 && k <= 34) ? 8'(200 + k - 3) : 8'd0;
            checks++;
            if (rd_valid !== (k >= 3 && k <= 34) || rd_data !== exp_d || rd_last !== (k == 34) || rd_underrun !== 1'b0) begin
                errors++;
                $display("FAIL b2b_out k=%0d valid=%b data=%0d last=%b underrun=%b required %b %0d %b 0",
                         k, rd_valid, rd_data, rd_last, rd_underrun, (k >= 3 && k <= 34), exp_d, (k == 34));
            end
            checks++;
            if (ram1_re !== (k >= 2 && k <= 33) || ram2_re !== 1'b0) begin
                errors++;
                $display("FAIL b2b_re k=%0d re1=%b re2=%b", k, ram1_re, ram2_re);
            end
            checks++;
            if (swap !== (k == 1) || bank_sel !== (k >= 1) || wr_ready !== (k >= 1)) begin
                errors++;
                $display("FAIL b2b_swap k=%0d swap=%b bank_sel=%b ready=%b required %b %b %b",
                         k, swap, bank_sel, wr_ready, (k == 1), (k >= 1), (k >= 1));
            end
            tick();
        end
        rd_start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int k = -5; k <= 12; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(55 + k);
            rd_start = (k == 0);
            #1;
            if (k == 12) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 8'd210 || ram2_we !== 1'b1 || ram2_waddr !== 5'd17) begin
                    errors++;
                    $display("FAIL midrst_pre valid=%b data=%0d we2=%b waddr=%0d required 1 210 1 17",
                             rd_valid, rd_data, ram2_we, ram2_waddr);
                end
            end
            if (k < 12) tick();
        end
        rd_start = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0 || ram2_we !== 1'b0 || ram1_re !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold ready=%b we2=%b re1=%b required 0 0 0", wr_ready, ram2_we, ram1_re);
        end
        tick();
        wr_valid = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'd0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next valid=%b data=%0d ready=%b required 0 0 0", rd_valid, rd_data, wr_ready);
        end
        reset = 1'b0;
        tick();
        #1;
        checks++;
        if (bank_sel !== 1'b0 || wr_ready !== 1'b1 || swap !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after bank_sel=%b ready=%b swap=%b valid=%b required 0 1 0 0",
                     bank_sel, wr_ready, swap, rd_valid);
        end
        for (int k = 0; k < 4; k++) begin
            rd_start = (k == 0);
            #1;
            if (rd_underrun === 1'b1) pulses++;
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_noread k=%0d rd_valid=%b required 0", k, rd_valid);
            end
            tick();
        end
        rd_start = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL midrst_underrun got %0d pulses required 1", pulses);
        end
        wr_valid = 1'b1;
        wr_data  = 8'd7;
        #1;
        checks++;
        if (ram1_we !== 1'b1 || ram2_we !== 1'b0 || ram1_waddr !== 5'd0) begin
            errors++;
            $display("FAIL midrst_wcnt we1=%b we2=%b waddr=%0d required 1 0 0", ram1_we, ram2_we, ram1_waddr);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_underrun();
        test_fill();
        test_replay_with_fill();
        test_replay_new_bank();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_bank_ctrl.md
Name: pingpong_bank_ctrl

Overview:
- Sequences the two line RAMs of the beatmap double buffer as a ping-pong pair.
- A producer (beat data generator) fills the write bank through a valid/ready handshake, while the VGA side replays the other bank on demand.
- Banks swap only when the write bank is full and the reader is idle, so a displayed frame never mixes old and new data.

Parameters:
- DATA_W, 8, width of one RAM word
- ADDR_W, 5, RAM address width
- DEPTH, 32, words per bank; must be ≤ 2**ADDR_W

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  producer word available
- wr_data  in  DATA_W  producer word
- wr_ready  out  1  controller accepts word this cycle
- rd_start  in  1  one-cycle request to replay the read bank
- rd_valid  out  1  rd_data is valid
- rd_data  out  DATA_W  replayed word
- rd_last  out  1  marks word DEPTH-1 of a replay
- rd_underrun  out  1  one-cycle pulse: rd_start with no valid read bank
- bank_sel  out  1  current write bank (0 = ram1, 1 = ram2); the read bank is ~bank_sel
- swap  out  1  one-cycle pulse in the cycle after a swap
- ram1_we, ram2_we  out  1  write enables
- ram1_waddr, ram2_waddr  out  ADDR_W  write addresses
- ram1_wdata, ram2_wdata  out  DATA_W  write data
- ram1_re, ram2_re  out  1  read enables
- ram1_raddr, ram2_raddr  out  ADDR_W  read addresses
- ram1_rdata, ram2_rdata  in  DATA_W  RAM read data; registered, 1-cycle latency after re

Behaviour:
- Reset values:
  - bank_sel=0, rbank_valid=0, wcnt=0.
  - Writer in FILL; reader in IDLE; rd_pend=0.
  - rd_valid=0, rd_last=0, rd_underrun=0, swap=0, rd_data=0.
  - All RAM we/re outputs 0.
  - wr_ready=0 while reset is high.
  - Reset mid-fill or mid-replay aborts immediately. RAM contents are not cleared.
- Writer FSM (FILL, FULL):
  - wr_ready=1 only in FILL.
  - On wr_valid&wr_ready: write bank bank_sel gets we=1, waddr=wcnt, wdata=wr_data; wcnt increments. The other bank's we stays 0.
  - wr_valid low stalls with no write.
  - Accepting word DEPTH-1 moves the writer to FULL. wr_ready is 0 in FULL.
- Swap:
  - Occurs in any cycle with writer==FULL and reader==IDLE.
  - Effects: bank_sel toggles, rbank_valid←1, wcnt←0, writer←FILL, swap pulses the next cycle.
  - Cost: exactly one cycle with wr_ready=0 between the last word of one fill and the first word of the next, when the reader is idle.
- Reader FSM (IDLE, READ, DRAIN):
  - IDLE→READ when (rd_start|rd_pend) & rbank_valid & no swap this cycle. This clears rd_pend and latches rbank_q=~bank_sel.
  - rd_start in a swap cycle sets rd_pend; the replay starts the next cycle on the newly swapped bank.
  - rd_start in IDLE with rbank_valid=0 and no swap: rd_underrun=1 for one cycle; the request is dropped.
  - rd_start during READ or DRAIN is ignored (no pend, no error).
  - READ: issue re=1 to bank rbank_q with raddr=0..DEPTH-1, one per cycle. After raddr DEPTH-1, go to DRAIN (1 cycle), then IDLE.
  - rd_valid/rd_data appear one cycle after each re, taken from rbank_q's rdata. rd_last accompanies the word from raddr DEPTH-1.
  - The read bank stays valid after a replay; repeated rd_start replays the same data until the next swap.
- Simultaneous events:
  - Writer writes and reader reads opposite banks concurrently; there is never a same-bank collision.
  - A swap is blocked during READ/DRAIN, and the writer waits in FULL.
- Replay latency: rd_start in cycle N → word0 on rd_data in cycle N+2 → word DEPTH-1 with rd_last in cycle N+DEPTH+1.

Test Plan:
- Reset, then push 0..31 with wr_valid held high → ram1_we for 32 cycles at addr 0..31; one wr_ready=0 cycle; swap pulses; bank_sel=1; first word of the next fill goes to ram2 addr 0.
- After the first fill, rd_start in cycle N → rd_valid high in N+2..N+33; rd_data=0..31; rd_last only in N+33; only ram1_re toggles.
- rd_start right after reset (no fill yet) → rd_underrun one cycle; rd_valid stays 0.
- Second fill completes during a replay → writer holds FULL with wr_ready=0 until DRAIN ends. Swap lands in the first IDLE cycle; the next rd_start returns the second fill's data (e.g. 100..131).
- rd_start coincident with a swap cycle → replay starts one cycle later from the new bank with no underrun. A second rd_start mid-READ produces no extra replay.
- Assert reset at word 10 of a replay and at word 17 of a fill → next cycle rd_valid=0, wr_ready=0. After release: bank_sel=0, wcnt=0, rd_start gives rd_underrun.
